mux4_1: RTL and testbench
=========================

MUX4_1 -- requirements
Module: mux4_1

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data input and of the data outputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i0  input  WIDTH  data input 0.
REQ-005 i1  input  WIDTH  data input 1.
REQ-006 i2  input  WIDTH  data input 2.
REQ-007 i3  input  WIDTH  data input 3.
REQ-008 s0  input  1  select bit, MSB of the select index.
REQ-009 s1  input  1  select bit, LSB of the select index.
REQ-010 en  input  1  capture enable for the registered path.
REQ-011 y  output  WIDTH  combinational mux output.
REQ-012 y_q  output  WIDTH  registered copy of y.
REQ-013 y_vld  output  1  y_q updated on the last rising edge.
REQ-014 sel_chg  output  1  one-cycle pulse when the sampled select differs from the previously sampled select.
REQ-015 y_par  output  1  even parity of y_q; present only when MUX4_1_PARITY_EN is defined.

Function
REQ-016 Select index SHALL be {s0,s1}: 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
REQ-017 y SHALL be purely combinational, with zero-cycle latency, and independent of clk, rst_n and en.
REQ-018 On a rising edge with en=1, y_q SHALL load the current y and y_vld SHALL be 1 in the following cycle.
REQ-019 On a rising edge with en=0, y_q SHALL hold its value and y_vld SHALL be 0 in the following cycle.
REQ-020 The block SHALL hold a 2-bit sel_prev register that loads {s0,s1} on every rising edge, regardless of en.
REQ-021 sel_chg SHALL be registered, and SHALL be 1 for exactly one cycle after an edge where {s0,s1} != sel_prev.
REQ-022 A select change held steady SHALL produce exactly one sel_chg pulse.
REQ-023 A change every cycle SHALL keep sel_chg asserted continuously.
REQ-024 Data-input changes with a constant select SHALL NOT assert sel_chg.
REQ-025 y SHALL be X-tolerant only in the selected input; if the selected input is unknown, y and y_q may be unknown.
REQ-026 For all WIDTH >= 1, all outputs SHALL be bitwise; there is no arithmetic and no width extension.

Reset
REQ-027 While rst_n=0, the following SHALL hold immediately, independent of clk: y_q=0, y_vld=0, sel_chg=0, sel_prev=00, y_par=0.
REQ-028 Reset asserted mid-operation SHALL clear all registers at once, and y SHALL continue to follow inputs.
REQ-029 On the first rising edge after rst_n rises, the select SHALL compare against 00, so a nonzero select then pulses sel_chg.

Configuration
REQ-030 Macro MUX4_1_PARITY_EN: when defined, y_par SHALL exist and SHALL equal the XOR-reduction of y_q, updated in the same edge as y_q with no extra latency.
REQ-031 When MUX4_1_PARITY_EN is undefined, the y_par port and its logic SHALL be absent, and all other behaviour is unchanged.

Verification
REQ-032 WIDTH=1; each select case has only the selected input at 1:
  - s0=0,s1=0,i0=1 -> y=1
  - s0=0,s1=1,i1=1 -> y=1
  - s0=1,s1=0,i2=1 -> y=1
  - s0=1,s1=1,i3=1 -> y=1
  - each case with the selected input at 0 -> y=0
REQ-033 WIDTH=8, i0=8'h11, i1=8'h22, i2=8'h33, i3=8'h44, all four selects, en=1 -> y_q equals the selected value one cycle after y, with y_vld=1.
REQ-034 en=0 for 3 cycles while the select cycles -> y_q holds its last captured value and y_vld=0.
REQ-035 Select 00 -> 10, held 4 cycles -> sel_chg=1 for exactly one cycle, then 0.
REQ-036 rst_n driven low mid-cycle with y_q=8'h44 -> y_q=0, y_vld=0 and sel_chg=0 before the next edge.
REQ-037 With MUX4_1_PARITY_EN: y_q=8'h07 -> y_par=1; y_q=8'h03 -> y_par=0.

Source files
------------

// File: rtl/mux4_1.sv
// -----------------------------------------------------------------------------
// mux4_1 -- 4:1 multiplexer with a combinational output, a registered copy,
// a capture-valid flag and a select-change pulse.
//
// Parameters:
//   WIDTH    bit width of each data input and of the data outputs (default 1)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   i0..i3   data inputs (WIDTH bits)
//   s0, s1   select bits; index is {s0,s1} (s0 is the MSB)
//   en       capture enable for the registered path
//   y        combinational mux output
//   y_q      registered copy of y, loaded on edges where en=1
//   y_vld    1 in the cycle after an edge where en=1
//   sel_chg  1-cycle pulse after an edge where {s0,s1} differs from the
//            select sampled on the previous edge
//   y_par    even parity (XOR-reduction) of y_q
//
// Optional build macro:
//   MUX4_1_PARITY_EN   when defined, adds the y_par output and its register.
// -----------------------------------------------------------------------------
module mux4_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s0,
  input  logic             s1,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_vld,
  output logic             sel_chg
`ifdef MUX4_1_PARITY_EN
  ,
  output logic             y_par
`endif
);

  // Even parity of a data word: 1 when the word holds an odd number of ones.
  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic [1:0]       sel_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] y_q_r;
  logic             y_vld_r;
  logic [1:0]       sel_prev_r;
  logic             sel_chg_r;

  assign sel_s = {s0, s1};

  // Combinational select of the data input addressed by {s0,s1}.
  always_comb begin
    y_s = {WIDTH{1'b0}};
    case (sel_s)
      2'b00:   y_s = i0;
      2'b01:   y_s = i1;
      2'b10:   y_s = i2;
      2'b11:   y_s = i3;
      default: y_s = {WIDTH{1'b0}};
    endcase
  end

  assign y = y_s;

  // Capture path and select-change detector; sel_prev tracks the select on
  // every edge, independent of en, so sel_chg sees every select transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r      <= {WIDTH{1'b0}};
      y_vld_r    <= 1'b0;
      sel_prev_r <= 2'b00;
      sel_chg_r  <= 1'b0;
    end else begin
      if (en) begin
        y_q_r <= y_s;
      end else begin
        y_q_r <= y_q_r;
      end
      y_vld_r    <= en;
      sel_prev_r <= sel_s;
      sel_chg_r  <= (sel_s != sel_prev_r);
    end
  end

  assign y_q     = y_q_r;
  assign y_vld   = y_vld_r;
  assign sel_chg = sel_chg_r;

`ifdef MUX4_1_PARITY_EN
  logic y_par_r;

  // Parity register loads from the same value as y_q on the same edge, so it
  // always matches the word currently held in y_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par_r <= 1'b0;
    end else if (en) begin
      y_par_r <= even_par(y_s);
    end else begin
      y_par_r <= y_par_r;
    end
  end

  assign y_par = y_par_r;
`endif

endmodule

// File: tb/tb_mux4_1.sv
// -----------------------------------------------------------------------------
// tb_mux4_1 -- self-checking bench for mux4_1.
// Two instances share clock, reset, select and enable: an 8-bit one and a
// 1-bit one. A behavioural model (input arrays indexed by the select, plus a
// per-edge record of what was captured) is compared against both instances
// every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_mux4_1;

  logic       clk;
  logic       rst_n;
  logic [7:0] i0, i1, i2, i3;
  logic       s0, s1, en;
  logic [7:0] y, y_q;
  logic       y_vld, sel_chg;
  logic       w0, w1, w2, w3;
  logic       y1, y_q1, y_vld1, sel_chg1;
`ifdef MUX4_1_PARITY_EN
  logic       y_par, y_par1;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  mux4_1 #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s0(s0), .s1(s1), .en(en),
    .y(y), .y_q(y_q), .y_vld(y_vld), .sel_chg(sel_chg)
`ifdef MUX4_1_PARITY_EN
    , .y_par(y_par)
`endif
  );

  mux4_1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i0(w0), .i1(w1), .i2(w2), .i3(w3),
    .s0(s0), .s1(s1), .en(en),
    .y(y1), .y_q(y_q1), .y_vld(y_vld1), .sel_chg(sel_chg1)
`ifdef MUX4_1_PARITY_EN
    , .y_par(y_par1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] exp_q   = 8'h00;
  logic       exp_q1  = 1'b0;
  logic       exp_vld = 1'b0;
  logic       exp_chg = 1'b0;
  int         m_prev  = 0;

  function automatic logic [7:0] pick8(input int idx);
    logic [7:0] v [4];
    v = '{i0, i1, i2, i3};
    return v[idx];
  endfunction

  function automatic logic pick1(input int idx);
    logic v [4];
    v = '{w0, w1, w2, w3};
    return v[idx];
  endfunction

  function automatic int sel_idx();
    return (s0 ? 2 : 0) + (s1 ? 1 : 0);
  endfunction

  // Reset wipes the whole recorded history at once.
  always @(negedge rst_n) begin
    exp_q   = 8'h00;
    exp_q1  = 1'b0;
    exp_vld = 1'b0;
    exp_chg = 1'b0;
    m_prev  = 0;
  end

  // Record each edge in the model, then compare all outputs shortly after.
  always begin
    @(posedge clk);
    if (rst_n) begin
      exp_chg = (sel_idx() != m_prev);
      m_prev  = sel_idx();
      exp_vld = en;
      if (en) begin
        exp_q  = pick8(sel_idx());
        exp_q1 = pick1(sel_idx());
      end
    end
    #2;
    chk("y",        {24'h0, y},     {24'h0, pick8(sel_idx())});
    chk("y_q",      {24'h0, y_q},   {24'h0, exp_q});
    chk("y_vld",    {31'h0, y_vld}, {31'h0, exp_vld});
    chk("sel_chg",  {31'h0, sel_chg}, {31'h0, exp_chg});
    chk("y1",       {31'h0, y1},    {31'h0, pick1(sel_idx())});
    chk("y_q1",     {31'h0, y_q1},  {31'h0, exp_q1});
    chk("sel_chg1", {31'h0, sel_chg1}, {31'h0, exp_chg});
`ifdef MUX4_1_PARITY_EN
    chk("y_par",    {31'h0, y_par}, {31'h0, ^exp_q});
    chk("y_par1",   {31'h0, y_par1}, {31'h0, exp_q1});
`endif
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_sel(input int idx);
    s0 = (idx >= 2);
    s1 = (idx % 2) == 1;
  endtask

  initial begin
    logic [7:0] vals [4];
    rst_n = 1'b0;
    i0 = 8'h00; i1 = 8'h00; i2 = 8'h00; i3 = 8'h00;
    w0 = 1'b0; w1 = 1'b0; w2 = 1'b0; w3 = 1'b0;
    s0 = 1'b0; s1 = 1'b0; en = 1'b0;

    // Reset state before any edge.
    #3;
    chk("rst_y_q",     {24'h0, y_q},   32'h0);
    chk("rst_y_vld",   {31'h0, y_vld}, 32'h0);
    chk("rst_sel_chg", {31'h0, sel_chg}, 32'h0);

    // Edge under reset with nonzero select and en: registers stay clear.
    i0 = 8'h11; i1 = 8'h22; i2 = 8'h33; i3 = 8'h44;
    set_sel(2); en = 1'b1;
    tick();
    chk("rst_hold_y_q",    {24'h0, y_q},     32'h0);
    chk("rst_hold_sel_chg", {31'h0, sel_chg}, 32'h0);
    chk("rst_y_follows",   {24'h0, y},       32'h33);

    // First edge after release compares against 00.
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("first_edge_chg", {31'h0, sel_chg}, 32'h1);
    chk("first_edge_y_q", {24'h0, y_q},     32'h33);

    // Four selects captured with en=1.
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      set_sel(k);
      #1;
      chk("cap_y", {24'h0, y}, {24'h0, vals[k]});
      tick();
      chk("cap_y_q",   {24'h0, y_q},   {24'h0, vals[k]});
      chk("cap_y_vld", {31'h0, y_vld}, 32'h1);
    end

    // en=0 for 3 cycles while the select cycles: y_q holds 8'h44.
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_sel(k);
      tick();
      chk("hold_y_q",   {24'h0, y_q},   32'h44);
      chk("hold_y_vld", {31'h0, y_vld}, 32'h0);
    end

    // Select 00 -> 10 held 4 cycles: exactly one sel_chg pulse.
    set_sel(0);
    tick();
    tick();
    chk("steady_chg", {31'h0, sel_chg}, 32'h0);
    set_sel(2);
    tick();
    chk("pulse_chg", {31'h0, sel_chg}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pulse_off_chg", {31'h0, sel_chg}, 32'h0);
    end

    // Data changes under constant select do not pulse sel_chg.
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i2 = 8'(k * 37 + 5);
      tick();
      chk("data_no_chg", {31'h0, sel_chg}, 32'h0);
    end

    // Select change on every cycle keeps sel_chg high.
    for (int k = 0; k < 4; k++) begin
      set_sel(k);
      tick();
      chk("cont_chg", {31'h0, sel_chg}, 32'h1);
    end

    // Mid-cycle reset with y_q = 8'h44: clears before the next edge.
    i3 = 8'h44;
    set_sel(3);
    tick();
    tick();
    chk("pre_rst_y_q", {24'h0, y_q}, 32'h44);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y_q",     {24'h0, y_q},     32'h0);
    chk("mid_rst_y_vld",   {31'h0, y_vld},   32'h0);
    chk("mid_rst_sel_chg", {31'h0, sel_chg}, 32'h0);
    i3 = 8'h5a;
    #1;
    chk("mid_rst_y", {24'h0, y}, 32'h5a);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1: only the selected input matches the tested value.
    for (int k = 0; k < 4; k++) begin
      for (int v = 0; v < 2; v++) begin
        w0 = (v == 0); w1 = (v == 0); w2 = (v == 0); w3 = (v == 0);
        case (k)
          0: w0 = (v == 1);
          1: w1 = (v == 1);
          2: w2 = (v == 1);
          default: w3 = (v == 1);
        endcase
        set_sel(k);
        #1;
        chk("w1_sel", {31'h0, y1}, 32'(v));
      end
    end

`ifdef MUX4_1_PARITY_EN
    // Parity of captured words.
    en = 1'b1;
    set_sel(0);
    i0 = 8'h07;
    tick();
    chk("par_07", {31'h0, y_par}, 32'h1);
    i0 = 8'h03;
    tick();
    chk("par_03", {31'h0, y_par}, 32'h0);
`endif

    // Randomized traffic checked by the model each cycle.
    for (int n = 0; n < 400; n++) begin
      i0 = 8'($urandom); i1 = 8'($urandom);
      i2 = 8'($urandom); i3 = 8'($urandom);
      w0 = 1'($urandom); w1 = 1'($urandom);
      w2 = 1'($urandom); w3 = 1'($urandom);
      en = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        set_sel(int'($urandom_range(0, 3)));
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
